// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sorting-network family (sorter, feeder and the
// result serializer). Holds the frame geometry and sorter pipeline depth so
// every block agrees on them.
//   data_t        : one sorted word
//   SORT_N        : words per frame (sorter width)
//   SORT_LATENCY  : sorter pipeline depth in clock edges
// ---------------------------------------------------------------------------
package sort_pkg;

    localparam int SORT_WIDTH   = 32;
    localparam int SORT_N       = 10;
    localparam int SORT_LATENCY = 8;

    typedef logic [SORT_WIDTH-1:0] data_t;

endpackage

// File: rtl/sort_valid_pipe.sv
// ---------------------------------------------------------------------------
// sort_valid_pipe
// Launch-tag delay line matched to the sorter latency. A tag enters at bit 0
// with launch_i and reaches the last bit exactly when the sorter output holds
// that frame's result.
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset (clears all tags)
//   launch_i  in   frame presented to the sorter this cycle
//   tap_o     out  sorter output carries a launched frame this cycle
//   any_o     out  at least one frame is in flight
// LATENCY must be 2 or more.
// ---------------------------------------------------------------------------
module sort_valid_pipe #(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic launch_i,
    output logic tap_o,
    output logic any_o
);

    logic [LATENCY-1:0] tag_q;
    logic [LATENCY-1:0] tag_d;

    always_comb begin
        tag_d = {tag_q[LATENCY-2:0], launch_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tap_o = tag_q[LATENCY-1];
    assign any_o = |tag_q;

endmodule

// File: rtl/sort_result_serializer.sv
// ---------------------------------------------------------------------------
// sort_result_serializer
// Drain side of the pipelined sorter. Captures each emerging sorted frame
// into a 2-slot buffer and streams its words out one per beat, lane 0 first,
// on a valid/ready interface with a last marker.
//   clk        in   rising-edge clock shared with the sorter
//   rst        in   asynchronous, active-high reset
//   launch     in   upstream presents a frame to the sorter this cycle
//   sort_in    in   sorter outputs, lane k = sort_k
//   out_data   out  current stream word (0 when out_valid=0)
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts the word at this edge
//   out_last   out  current word is the final word of its frame
//   overflow   out  sticky: a frame was dropped because both slots were full
//   busy       out  a frame is in flight in the sorter or buffered here
//
// Handshake: a beat happens at a rising edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0, out_data and out_last hold steady;
// out_valid never drops without a beat.
// ---------------------------------------------------------------------------
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int WIDTH   = SORT_WIDTH,
    parameter int LATENCY = SORT_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               launch,
    input  logic [N*WIDTH-1:0] sort_in,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overflow,
    output logic               busy
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic tap;
    logic tags_any;

    sort_valid_pipe #(
        .LATENCY (LATENCY)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .launch_i (launch),
        .tap_o    (tap),
        .any_o    (tags_any)
    );

    // Buffer storage is deliberately unreset: contents are only read once a
    // slot has been written, and occupancy gates everything visible.
    logic [N*WIDTH-1:0] slot_q [2];

    logic [1:0]       occ_q,  occ_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic             ovf_q,  ovf_d;

    logic             beat;
    logic             last_beat;
    logic             cap;
    logic             drop;
    logic [N*WIDTH-1:0] head_frame;

    always_comb begin
        beat      = out_valid && out_ready;
        last_beat = beat && (idx_q == LAST_IDX);
        // When full, a last-beat pop frees the head slot at the same edge;
        // tail equals head in that state, so the capture lands in the freed slot.
        cap       = tap && ((occ_q != 2'd2) || last_beat);
        drop      = tap && !cap;

        occ_d = occ_q;
        if (cap && !last_beat) begin
            occ_d = occ_q + 2'd1;
        end else if (!cap && last_beat) begin
            occ_d = occ_q - 2'd1;
        end

        head_d = last_beat ? ~head_q : head_q;
        tail_d = cap ? ~tail_q : tail_q;

        idx_d = idx_q;
        if (beat) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            idx_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            idx_q  <= idx_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            slot_q[tail_q] <= sort_in;
        end
    end

    always_comb begin
        head_frame = slot_q[head_q];
        out_valid  = (occ_q != 2'd0);
        out_data   = out_valid ? head_frame[int'(idx_q)*WIDTH +: WIDTH] : '0;
        out_last   = out_valid && (idx_q == LAST_IDX);
        overflow   = ovf_q;
        busy       = out_valid || tags_any;
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_sort_result_serializer
// Directed bench for sort_result_serializer. A small sorter stand-in delays
// the launched frame by SORT_LATENCY edges and presents it on sort_in; any
// cycle without a launch carries a junk pattern so stray captures show up.
// ---------------------------------------------------------------------------
module tb_sort_result_serializer;
    import sort_pkg::*;

    localparam int N   = SORT_N;
    localparam int W   = SORT_WIDTH;
    localparam int LAT = SORT_LATENCY;

    typedef logic [N*W-1:0] frame_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           launch;
    frame_t         launch_data;
    frame_t         sort_in;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           overflow;
    logic           busy;

    frame_t         fr_pipe [LAT];

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [W-1:0]   exp_q[$];
    logic           exp_l_q[$];

    sort_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch),
        .sort_in   (sort_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow),
        .busy      (busy)
    );

    // ---------------- clock / sorter stand-in ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        fr_pipe[0] <= launch ? launch_data : {N{32'hDEADBEEF}};
        for (int i = 1; i < LAT; i++) begin
            fr_pipe[i] <= fr_pipe[i-1];
        end
    end

    assign sort_in = fr_pipe[LAT-1];

    // ---------------- driver helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        launch    = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        exp_q.delete();
        exp_l_q.delete();
    endtask

    function automatic frame_t ramp(input logic [W-1:0] base, input logic [W-1:0] step);
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f[k*W +: W] = base + step * W'(k);
        end
        return f;
    endfunction

    task automatic push_frame(input frame_t f);
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(f[k*W +: W]);
            exp_l_q.push_back(k == N - 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst       = 1'b1;
        launch    = 1'b0;
        out_ready = 1'b1;
        launch_data = '0;
        tick;
        tick;
        n_cmp++;
        if ({out_valid, out_last, overflow, busy, out_data} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_hold: got v=%b l=%b ovf=%b busy=%b d=%h, want all 0",
                     out_valid, out_last, overflow, busy, out_data);
        end
        rst = 1'b0;
        tick;
        n_cmp++;
        if ({out_valid, out_last, overflow, busy, out_data} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_release: got v=%b l=%b ovf=%b busy=%b d=%h, want all 0",
                     out_valid, out_last, overflow, busy, out_data);
        end
    endtask

    task automatic test_single;
        logic         ev;
        logic [W-1:0] ed;
        do_reset;
        out_ready   = 1'b1;
        launch_data = ramp(10, 10);
        launch      = 1'b1;
        tick;                       // E0
        launch = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy_e0: got %b, want 1", busy);
        end
        for (int k = 1; k <= 19; k++) begin
            tick;                   // now just after Ek
            ev = (k >= 8) && (k <= 17);
            ed = ev ? W'(10 * (k - 7)) : '0;
            n_cmp++;
            if (out_valid !== ev || out_data !== ed || out_last !== (k == 17)) begin
                n_bad++;
                $display("FAIL single_e%0d: got v=%b d=%0d l=%b, want v=%b d=%0d l=%b",
                         k, out_valid, out_data, out_last, ev, ed, (k == 17));
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_end: got %b, want 0", busy);
        end
    endtask

    task automatic test_backpressure;
        frame_t       f;
        logic [W-1:0] exp_d;
        logic         exp_l;
        logic [W-1:0] hold_d;
        logic         hold_l;
        logic         hold_v;
        do_reset;
        f = ramp(10, 10);
        push_frame(f);
        hold_v = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            launch      = (c == 0);
            launch_data = f;
            if (hold_v) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
                    n_bad++;
                    $display("FAIL bp_hold c%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             c, out_valid, out_data, out_last, hold_d, hold_l);
                end
            end
            out_ready = (c % 3 == 0);
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL bp_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            tick;
        end
        launch    = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_timeout: got %0d words left, want 0", exp_q.size());
        end
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_extra: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_double_buffer;
        frame_t       fa;
        frame_t       fb;
        logic [W-1:0] exp_d;
        logic         exp_l;
        do_reset;
        fa = ramp(1, 1);
        fb = ramp(1000, 3);
        push_frame(fa);
        push_frame(fb);
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            launch      = (c <= 1);
            launch_data = (c == 0) ? fa : fb;
            out_ready   = (c >= 12);
            if (c == 11) begin
                n_cmp++;
                if (out_valid !== 1'b1 || overflow !== 1'b0 || busy !== 1'b1 || out_data !== fa[W-1:0]) begin
                    n_bad++;
                    $display("FAIL dbuf_full: got v=%b ovf=%b busy=%b d=%h, want 1 0 1 %h",
                             out_valid, overflow, busy, out_data, fa[W-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL dbuf_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            tick;
        end
        launch = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dbuf_end: got %0d left v=%b, want 0 left v=0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_overflow;
        frame_t       f1;
        frame_t       f2;
        frame_t       f3;
        logic [W-1:0] exp_d;
        logic         exp_l;
        do_reset;
        f1 = ramp(11, 1);
        f2 = ramp(22, 1);
        f3 = ramp(33, 1);
        push_frame(f1);
        push_frame(f2);
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            launch      = (c <= 2);
            launch_data = (c == 0) ? f1 : (c == 1) ? f2 : f3;
            out_ready   = (c >= 14);
            if (c == 10) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_e9: got %b, want 0", overflow);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (overflow !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ovf_e10: got %b, want 1", overflow);
                end
            end
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL ovf_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            tick;
        end
        launch = 1'b0;
        tick;
        tick;
        tick;
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_end: got %0d left v=%b ovf=%b busy=%b, want 0 left v=0 ovf=1 busy=0",
                     exp_q.size(), out_valid, overflow, busy);
        end
    endtask

    task automatic test_simul_pop;
        frame_t       f1;
        frame_t       f2;
        frame_t       f3;
        logic [W-1:0] exp_d;
        logic         exp_l;
        do_reset;
        f1 = ramp(100, 2);
        f2 = ramp(200, 2);
        f3 = ramp(300, 2);
        push_frame(f1);
        push_frame(f2);
        push_frame(f3);
        out_ready = 1'b1;
        // Third capture at E18 coincides with frame 1's last beat.
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            launch      = (c == 0) || (c == 1) || (c == 10);
            launch_data = (c == 0) ? f1 : (c == 1) ? f2 : f3;
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL simul_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            tick;
        end
        launch = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_end: got %0d left ovf=%b v=%b, want 0 left ovf=0 v=0",
                     exp_q.size(), overflow, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        frame_t       f [3];
        logic [W-1:0] exp_d;
        logic         exp_l;
        do_reset;
        f[0] = ramp(32'h1000, 1);
        f[1] = ramp(32'h2000, 1);
        f[2] = ramp(32'h3000, 1);
        for (int i = 0; i < 3; i++) push_frame(f[i]);
        out_ready = 1'b1;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            launch      = (c % 10 == 0) && (c < 30);
            launch_data = f[(c / 10) % 3];
            if (c >= 9 && c <= 38) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_bubble c%0d: got v=%b, want 1", c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL b2b_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            tick;
        end
        launch = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got %0d left ovf=%b, want 0 left ovf=0", exp_q.size(), overflow);
        end
    endtask

    task automatic test_reset_mid_frame;
        frame_t f;
        frame_t g;
        do_reset;
        f = ramp(100, 1);
        g = ramp(900, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            launch      = (c == 0) || (c == 9);
            launch_data = (c == 9) ? g : f;
            tick;
        end
        launch = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'd104) begin
            n_bad++;
            $display("FAIL rstmid_word4: got v=%b d=%0d, want v=1 d=104", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_last, overflow, busy, out_data} !== 36'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got v=%b l=%b ovf=%b busy=%b d=%h, want all 0",
                     out_valid, out_last, overflow, busy, out_data);
        end
        tick;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_ghost c%0d: got v=%b busy=%b d=%h, want v=0 busy=0",
                         c, out_valid, busy, out_data);
            end
        end
    endtask

    task automatic test_extremes;
        frame_t       f;
        logic [W-1:0] lanes [N];
        logic [W-1:0] exp_d;
        logic         exp_l;
        do_reset;
        lanes = '{32'h0, 32'h0, 32'h5, 32'h5, 32'h7, 32'h7,
                  32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int k = 0; k < N; k++) f[k*W +: W] = lanes[k];
        push_frame(f);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            launch      = (c == 0);
            launch_data = f;
            if (out_valid && out_ready) begin
                exp_d = exp_q.pop_front();
                exp_l = exp_l_q.pop_front();
                n_cmp++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    n_bad++;
                    $display("FAIL ext_beat: got d=%h l=%b, want d=%h l=%b",
                             out_data, out_last, exp_d, exp_l);
                end
            end
            tick;
        end
        launch = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ext_timeout: got %0d words left, want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst         = 1'b1;
        launch      = 1'b0;
        launch_data = '0;
        out_ready   = 1'b0;
        test_reset;
        test_single;
        test_backpressure;
        test_double_buffer;
        test_overflow;
        test_simul_pop;
        test_back_to_back;
        test_reset_mid_frame;
        test_extremes;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run by 200000, want earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
